fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_queue.sv | 57 +++++
 rtl/fetch_unit.sv | 92 +++++++++
 tb/tb_fetch_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its prefetch queue.
package fetch_pkg;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } q_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry prefetch FIFO with combinational head; flush overrides push and pop.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  q_entry_t   push_entry,
   input  logic       pop,
   input  logic       flush,
   output q_entry_t   head,
   output logic [2:0] occ
);

   localparam int PW = $clog2(DEPTH);

   q_entry_t      mem [DEPTH];
   logic [PW-1:0] wr_ptr_reg;
   logic [PW-1:0] rd_ptr_reg;
   logic [2:0]    occ_reg;
   logic          do_push;
   logic          do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign do_push = push && !flush;
   assign do_pop  = pop && !flush && (occ_reg != 3'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         occ_reg    <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         occ_reg    <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         occ_reg <= occ_reg + 3'(do_push) - 3'(do_pop);
      end
   end

   // Storage carries no reset; the head is only meaningful while occ is non-zero.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= push_entry;
   end

   assign head = mem[rd_ptr_reg];
   assign occ  = occ_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited request issue, in-order response tracking,
// redirect with stale-response dropping, and a prefetch queue feeding IF/ID.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        pc_write,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_valid
);

   logic [31:0] fetch_pc_reg, fetch_pc_next;
   logic [31:0] rsp_pc_reg, rsp_pc_next;
   logic [2:0]  out_reg, out_next;
   logic [2:0]  drop_reg, drop_next;
   logic [2:0]  occ;
   logic        hs;
   logic        push;
   logic        pop;
   q_entry_t    head;
   q_entry_t    push_entry;

   // Credit check uses registered counts only, so a same-cycle response never frees a slot early.
   assign imem_req_valid = rst_n && !redirect_valid &&
                           (({1'b0, occ} + {1'b0, out_reg}) < 4'(DEPTH));
   assign imem_req_addr  = fetch_pc_reg;
   assign hs             = imem_req_valid && imem_req_ready;
   assign push           = imem_rsp_valid && (drop_reg == 3'd0) && !redirect_valid;
   assign pop            = instr_valid && pc_write && !redirect_valid;
   assign push_entry     = '{pc: rsp_pc_reg, instr: imem_rsp_data};

   always_comb begin
      fetch_pc_next = fetch_pc_reg;
      rsp_pc_next   = rsp_pc_reg;
      out_next      = out_reg + 3'(hs) - 3'(imem_rsp_valid);
      drop_next     = drop_reg;
      if (redirect_valid) begin
         fetch_pc_next = redirect_pc;
         rsp_pc_next   = redirect_pc;
         // Every request still in flight belongs to the old path.
         drop_next     = out_reg - 3'(imem_rsp_valid);
      end else begin
         if (hs)   fetch_pc_next = fetch_pc_reg + 32'd4;
         if (push) rsp_pc_next   = rsp_pc_reg + 32'd4;
         if (imem_rsp_valid && (drop_reg != 3'd0)) drop_next = drop_reg - 3'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_reg <= RESET_PC;
         rsp_pc_reg   <= RESET_PC;
         out_reg      <= '0;
         drop_reg     <= '0;
      end else begin
         fetch_pc_reg <= fetch_pc_next;
         rsp_pc_reg   <= rsp_pc_next;
         out_reg      <= out_next;
         drop_reg     <= drop_next;
      end
   end

   fetch_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .flush      (redirect_valid),
      .head       (head),
      .occ        (occ)
   );

   assign instr_valid = (occ != 3'd0);
   assign instr       = instr_valid ? head.instr : NOP_INSTR;
   assign instr_pc    = instr_valid ? head.pc : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory with configurable latency, a queue-based
// reference model of the fetch path, and directed scenarios with literal expectations.
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam int          DEPTH    = 3;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready = 1'b0;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data  = 32'h0;
   logic        pc_write       = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc    = 32'h0;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;

   always #5 clk = ~clk;

   fetch_unit #(
      .RESET_PC (RESET_PC),
      .DEPTH    (DEPTH)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .pc_write       (pc_write),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_valid    (instr_valid)
   );

   typedef struct { logic [31:0] addr; int due; } mreq_t;
   typedef struct { logic [31:0] addr; bit stale; } flight_t;
   typedef struct { logic [31:0] pc; logic [31:0] word; } ent_t;

   mreq_t       mem_q[$];
   flight_t     infl[$];
   ent_t        fifo[$];
   logic [31:0] dlog[$];
   logic [31:0] m_fetch_pc = RESET_PC;
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          lat      = 1;
   bit          cfg_ready    = 1'b1;
   bit          cfg_pc_write = 1'b1;
   bit          rd_pend      = 1'b0;
   logic [31:0] rd_target    = 32'h0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   function automatic logic [31:0] dget(input int i);
      return (i < dlog.size()) ? dlog[i] : 32'hDEAD_BEEF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock cycle: drive at the falling edge, compare against the model, then advance it.
   task automatic cycle();
      bit      rsp_now;
      bit      exp_rv;
      flight_t f;
      rsp_now        = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
      imem_rsp_valid = rsp_now;
      imem_rsp_data  = rsp_now ? mem_word(mem_q[0].addr) : 32'h0;
      imem_req_ready = cfg_ready;
      pc_write       = cfg_pc_write;
      redirect_valid = rd_pend;
      redirect_pc    = rd_pend ? rd_target : 32'h0;
      #1;
      exp_rv = !rd_pend && ((fifo.size() + infl.size()) < DEPTH);
      chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
      if (exp_rv) chk("req_addr", imem_req_addr, m_fetch_pc);
      chk("instr_valid", 32'(instr_valid), 32'(fifo.size() > 0));
      chk("instr", instr, (fifo.size() > 0) ? fifo[0].word : NOP_INSTR);
      chk("instr_pc", instr_pc, (fifo.size() > 0) ? fifo[0].pc : 32'h0);

      if (rsp_now) mem_q.delete(0);
      if (imem_req_valid && cfg_ready) mem_q.push_back('{imem_req_addr, cyc + lat});
      if (instr_valid && cfg_pc_write && !rd_pend) begin
         dlog.push_back(instr_pc);
         $display("cycle %0d: deliver pc=%h instr=%h", cyc, instr_pc, instr);
      end

      if ((fifo.size() > 0) && cfg_pc_write && !rd_pend) fifo.delete(0);
      if (rsp_now && (infl.size() > 0)) begin
         f = infl.pop_front();
         if (!rd_pend && !f.stale) begin
            chk("no_push_when_full", 32'(fifo.size() < DEPTH), 32'd1);
            fifo.push_back('{f.addr, mem_word(f.addr)});
         end
      end
      if (exp_rv && cfg_ready) begin
         infl.push_back('{m_fetch_pc, 1'b0});
         m_fetch_pc = m_fetch_pc + 32'd4;
      end
      if (rd_pend) begin
         $display("cycle %0d: redirect to %h", cyc, rd_target);
         fifo.delete();
         foreach (infl[i]) infl[i].stale = 1'b1;
         m_fetch_pc = rd_target;
         rd_pend    = 1'b0;
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic apply_reset();
      rst_n          = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      pc_write       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      #1;
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_instr_pc", instr_pc, 32'h0);
      $display("cycle %0d: reset asserted", cyc);
      mem_q.delete();
      infl.delete();
      fifo.delete();
      m_fetch_pc = RESET_PC;
      rd_pend    = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("first_req_valid", 32'(imem_req_valid), 32'd1);
      chk("first_req_addr", imem_req_addr, RESET_PC);
   endtask

   initial begin
      int mark;
      int breaks;
      @(negedge clk);
      apply_reset();

      // Back-to-back stream, latency 1.
      run(20);
      chk("stream_count", 32'(dlog.size()), 32'd18);
      for (int i = 0; i < 4; i++) chk($sformatf("stream_pc_%0d", i), dget(i), 32'(i * 4));

      // Stall with a full queue, then release.
      cfg_pc_write = 1'b0;
      run(5);
      chk("hold_req_valid", 32'(imem_req_valid), 32'd0);
      chk("hold_instr_pc", instr_pc, 32'h48);
      chk("hold_instr", instr, mem_word(32'h48));
      cfg_pc_write = 1'b1;
      run(6);
      chk("release_count", 32'(dlog.size()), 32'd24);
      breaks = 0;
      for (int i = 1; i < dlog.size(); i++) if (dlog[i] != dlog[i-1] + 32'd4) breaks++;
      chk("stream_contiguous", 32'(breaks), 32'd0);

      // Redirect with two requests outstanding, latency 3.
      cfg_ready = 1'b0;
      run(8);
      lat = 3;
      cfg_ready = 1'b1;
      run(2);
      mark = dlog.size();
      rd_pend = 1'b1;
      rd_target = 32'h100;
      run(1);
      run(12);
      chk("redirect_first_pc", dget(mark), 32'h100);

      // Redirect colliding with a response and a pop.
      lat = 1;
      run(10);
      chk("pre_redirect_valid", 32'(instr_valid), 32'd1);
      mark = dlog.size();
      rd_pend = 1'b1;
      rd_target = 32'h200;
      run(1);
      chk("flush_empty", 32'(instr_valid), 32'd0);
      run(6);
      chk("collide_first_pc", dget(mark), 32'h200);

      // Address wrap at the top of the address space.
      run(4);
      mark = dlog.size();
      rd_pend = 1'b1;
      rd_target = 32'hFFFF_FFF8;
      run(1);
      run(8);
      chk("wrap_pc_0", dget(mark), 32'hFFFF_FFF8);
      chk("wrap_pc_1", dget(mark + 1), 32'hFFFF_FFFC);
      chk("wrap_pc_2", dget(mark + 2), 32'h0000_0000);

      // Reset with two outstanding requests and one queued instruction.
      cfg_ready = 1'b0;
      run(8);
      lat = 3;
      cfg_pc_write = 1'b0;
      cfg_ready = 1'b1;
      run(3);
      cfg_ready = 1'b0;
      run(1);
      chk("pre_reset_valid", 32'(instr_valid), 32'd1);
      apply_reset();
      cfg_ready = 1'b1;
      cfg_pc_write = 1'b1;
      lat = 1;
      mark = dlog.size();
      run(6);
      chk("post_reset_first_pc", dget(mark), RESET_PC);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
